alu_1bit: RTL and testbench
===========================

// Module: alu_1bit
// PURPOSE
//  Registered 1-bit (WIDTH-generic) ALU: ADD, SUBTRACT, AND, OR, NAND, NOR.
//  Produces a result, carry/borrow-out, zero flag (Z) and an A>B flag.
//  Leaf datapath block; bit-slice building unit for wider ALUs in the design.
// PARAMETERS
//  WIDTH  1  operand/result width in bits (spec and tests target WIDTH=1)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      reset, asynchronous, active-high
//  opcode    in   3      operation select (see BEHAVIOUR)
//  input1    in   WIDTH  operand A
//  input2    in   WIDTH  operand B
//  carryin   in   1      carry-in (ADD) / borrow-in (SUB); ignored by logic ops
//  out       out  WIDTH  result
//  carryout  out  1      carry-out (ADD) / borrow-out (SUB); 0 otherwise
//  flag1     out  1      Z: 1 when out == 0
//  flag2     out  1      1 when input1 > input2 (unsigned)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (clk, rst).
//  - rst=1: out=0, carryout=0, flag1=1, flag2=0 immediately, held while asserted.
//  - All outputs registered; latency 1 cycle: inputs sampled at edge N appear
//    after edge N. No handshake; new operation accepted every cycle.
//  - Opcodes: 000 ADD  {carryout,out} = A + B + carryin
//             001 SUB  {borrow,out}  = A - B - carryin; carryout = borrow
//                      (1 bit: out=A^B^cin, bo=(~A&B)|(~(A^B)&cin))
//             010 AND  011 OR  100 NAND  101 NOR  (bitwise; carryout=0)
//             110,111  reserved: out=0, carryout=0 (unless ALU_XOR_EN)
//  - flag1 computed from the registered-next result (same cycle as out).
//  - flag2 independent of opcode: unsigned compare of input1 vs input2.
//  - Any X/Z on carryin must not affect logic-op results or flags.
//  - Reset deasserting mid-stream: first valid result on the first edge
//    after rst falls; no state beyond the output registers.
// CONFIGURATION
//  ALU_XOR_EN defined: opcode 110 = XOR (A^B), 111 = XNOR (~(A^B)),
//    carryout=0, flags as usual.
//  ALU_XOR_EN undefined: 110/111 are reserved -> out=0, carryout=0, flag1=1.
// STRUCTURE
//  - alu_pkg: opcode localparams OP_ADD..OP_NOR, OP_XOR, OP_XNOR.
//  - One sub-module alu_addsub: combinational WIDTH-bit add/subtract with
//    carry/borrow in/out; top holds op mux, flag logic, output registers.
// TESTING
//  - rst=1 with any inputs -> out=0, carryout=0, flag1=1, flag2=0.
//  - ADD, all 8 (A,B,cin): A=1,B=1,cin=1 -> out=1,carryout=1,flag1=0;
//    A=0,B=0,cin=0 -> out=0,carryout=0,flag1=1; results one cycle later.
//  - SUB, all 8: A=0,B=1,cin=0 -> out=1,carryout=1; A=1,B=0,cin=1 ->
//    out=0,carryout=0,flag1=1,flag2=1.
//  - Logic ops, carryin=X: AND 1,1 -> 1; OR 0,0 -> 0,Z=1; NAND 1,1 -> 0,Z=1;
//    NOR 0,0 -> 1; carryout=0 throughout; flag2=1 only for A=1,B=0.
//  - Opcode 110 with A=1,B=0: without ALU_XOR_EN -> out=0,flag1=1;
//    with ALU_XOR_EN -> out=1,flag1=0.
//  - Assert rst mid-sequence after ADD 1,1,1 -> outputs clear without a clock
//    edge; after release next edge yields fresh result.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU slice and its add/subtract unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-in/borrow-in and carry/borrow-out.
module alu_addsub #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH:0] sum;

  // The extra top bit holds the carry for add and the borrow for subtract.
  always_comb begin
    if (sub)
      sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    else
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  assign res  = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];

endmodule

// File: rtl/alu_1bit.sv
// Registered bit-slice ALU: add/sub/and/or/nand/nor with carry, zero and A>B flags.
// Define ALU_XOR_EN to turn opcodes 110/111 into XOR/XNOR instead of reserved zeros.
module alu_1bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carryin,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             flag1,
  output logic             flag2
);

  logic [WIDTH-1:0] as_res;
  logic             as_cout;
  logic [WIDTH-1:0] res_p0;
  logic             co_p0;
  logic [WIDTH-1:0] out_p1;
  logic             co_p1;
  logic             zf_p1;
  logic             gt_p1;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (input1),
    .b    (input2),
    .cin  (carryin),
    .sub  (opcode == OP_SUB),
    .res  (as_res),
    .cout (as_cout)
  );

  // Stage p0: operation select. Logic ops never touch carryin, so an
  // unknown carry-in cannot leak into their result or flags.
  always_comb begin
    res_p0 = '0;
    co_p0  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        res_p0 = as_res;
        co_p0  = as_cout;
      end
      OP_AND:  res_p0 = input1 & input2;
      OP_OR:   res_p0 = input1 | input2;
      OP_NAND: res_p0 = ~(input1 & input2);
      OP_NOR:  res_p0 = ~(input1 | input2);
`ifdef ALU_XOR_EN
      OP_XOR:  res_p0 = input1 ^ input2;
      OP_XNOR: res_p0 = ~(input1 ^ input2);
`endif
      default: res_p0 = '0;
    endcase
  end

  // Stage p1: output registers; reset forces the zero flag high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p1 <= '0;
      co_p1  <= 1'b0;
      zf_p1  <= 1'b1;
      gt_p1  <= 1'b0;
    end else begin
      out_p1 <= res_p0;
      co_p1  <= co_p0;
      zf_p1  <= (res_p0 == '0);
      gt_p1  <= (input1 > input2);
    end
  end

  assign out      = out_p1;
  assign carryout = co_p1;
  assign flag1    = zf_p1;
  assign flag2    = gt_p1;

endmodule

// File: tb/tb_alu_1bit.sv
// Scoreboard bench for alu_1bit: expected results queued at drive time, checked one edge later.
module tb_alu_1bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       input1;
  logic       input2;
  logic       carryin;
  logic       out;
  logic       carryout;
  logic       flag1;
  logic       flag2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] sb[$];
  string      tq[$];
  logic [3:0] mon_e;
  string      mon_t;

  alu_1bit #(.WIDTH(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .input1   (input1),
    .input2   (input2),
    .carryin  (carryin),
    .out      (out),
    .carryout (carryout),
    .flag1    (flag1),
    .flag2    (flag2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {out, carryout, flag1, flag2}
  function automatic logic [3:0] model(input logic [2:0] op, input logic a, input logic b,
                                       input logic c);
    int   s;
    logic o;
    logic co;
    o  = 1'b0;
    co = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(c); o = s[0]; co = s[1]; end
      3'd1: begin s = int'(a) - int'(b) - int'(c); o = s[0]; co = (s < 0); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = ~(a & b);
      3'd5: o = ~(a | b);
`ifdef ALU_XOR_EN
      3'd6: o = a ^ b;
      3'd7: o = ~(a ^ b);
`endif
      default: o = 1'b0;
    endcase
    return {o, co, (o == 1'b0), (a > b)};
  endfunction

  task automatic drive(input logic [2:0] op, input logic a, input logic b, input logic c,
                       input logic cx);
    @(negedge clk);
    opcode  = op;
    input1  = a;
    input2  = b;
    carryin = cx ? 1'bx : c;
    sb.push_back(model(op, a, b, c));
    tq.push_back($sformatf("op%0d a%0d b%0d c%0d", op, a, b, c));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_t = tq.pop_front();
      check({mon_t, " out"},   out,      mon_e[3]);
      check({mon_t, " co"},    carryout, mon_e[2]);
      check({mon_t, " flag1"}, flag1,    mon_e[1]);
      check({mon_t, " flag2"}, flag2,    mon_e[0]);
    end
  end

  initial begin
    rst     = 1'b1;
    opcode  = 3'd0;
    input1  = 1'b1;
    input2  = 1'b0;
    carryin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out",   out,      1'b0);
    check("rst co",    carryout, 1'b0);
    check("rst flag1", flag1,    1'b1);
    check("rst flag2", flag2,    1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) drive(3'd0, i[2], i[1], i[0], 1'b0);
    for (int i = 0; i < 8; i++) drive(3'd1, i[2], i[1], i[0], 1'b0);
    for (int op = 2; op < 6; op++)
      for (int i = 0; i < 4; i++) drive(op[2:0], i[1], i[0], 1'b0, 1'b1);
    for (int op = 6; op < 8; op++)
      for (int i = 0; i < 4; i++) drive(op[2:0], i[1], i[0], 1'b0, 1'b0);

    // Mid-stream asynchronous reset after ADD 1,1,1
    drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async out",   out,      1'b0);
    check("async co",    carryout, 1'b0);
    check("async flag1", flag1,    1'b1);
    check("async flag2", flag2,    1'b0);
    @(negedge clk);
    rst = 1'b0;
    opcode  = 3'd1;
    input1  = 1'b1;
    input2  = 1'b0;
    carryin = 1'b0;
    sb.push_back(model(3'd1, 1'b1, 1'b0, 1'b0));
    tq.push_back("post-rst sub");
    drive(3'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("sb drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
